// File: rtl/qpsk_pkg.sv
// Shared types and constants for the QPSK transmit frame scheduler.
package qpsk_pkg;

    localparam int FRAME_W   = 40;
    localparam int PAYLOAD_W = 24;

    localparam logic [7:0] HEAD_DEF = 8'hFF;
    localparam logic [7:0] TAIL_DEF = 8'hFF;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter; combinational one-hot grant.
module rr_arb2
    import qpsk_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        unique case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            // Tie goes to whichever requester was not served last.
            2'b11:   grant = last ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/qpsk_tx_sched.sv
// Round-robin frame scheduler feeding qpsk_mod.para_in with {HEAD, payload, TAIL}.
// Optional macro QPSK_TX_IDLE_FILL_EN: load filler frames instead of going idle.
module qpsk_tx_sched
    import qpsk_pkg::*;
#(
    parameter logic [7:0] HEAD      = HEAD_DEF,
    parameter logic [7:0] TAIL      = TAIL_DEF,
    parameter int         FRAME_CYC = 4000
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [1:0]             req,
    input  logic [PAYLOAD_W-1:0]   data0,
    input  logic [PAYLOAD_W-1:0]   data1,
    output logic [1:0]             gnt,
    output logic [FRAME_W-1:0]     para_out,
    output logic                   frame_vld,
    output logic                   frame_start,
    output logic                   busy,
    output logic [15:0]            frame_cnt
);

    localparam int CNT_W = $clog2(FRAME_CYC);

    state_t               state;
    logic [CNT_W-1:0]     cnt;
    logic                 last;
    logic [1:0]           grant;
    logic [PAYLOAD_W-1:0] data_g;

    rr_arb2 u_arb (
        .req   (req),
        .last  (last),
        .grant (grant)
    );

    assign data_g = grant[1] ? data1 : data0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            last        <= 1'b1;
            gnt         <= 2'b00;
            para_out    <= '0;
            frame_vld   <= 1'b0;
            frame_start <= 1'b0;
            busy        <= 1'b0;
            frame_cnt   <= 16'h0000;
        end else begin
            gnt         <= 2'b00;
            frame_start <= 1'b0;
            if (state == SEND && cnt != '0) begin
                cnt <= cnt - CNT_W'(1);
            end else if (|req) begin
                // Frame boundary with a pending payload: load it back-to-back.
                para_out    <= {HEAD, data_g, TAIL};
                gnt         <= grant;
                last        <= grant[1];
                frame_start <= 1'b1;
                frame_vld   <= 1'b1;
                busy        <= 1'b1;
                cnt         <= CNT_W'(FRAME_CYC - 1);
                frame_cnt   <= frame_cnt + 16'd1;
                state       <= SEND;
            end else begin
`ifdef QPSK_TX_IDLE_FILL_EN
                // Keep the carrier alive with an empty payload; arbitration history untouched.
                para_out    <= {HEAD, {PAYLOAD_W{1'b0}}, TAIL};
                frame_start <= 1'b1;
                frame_vld   <= 1'b1;
                busy        <= 1'b1;
                cnt         <= CNT_W'(FRAME_CYC - 1);
                frame_cnt   <= frame_cnt + 16'd1;
                state       <= SEND;
`else
                state       <= IDLE;
                frame_vld   <= 1'b0;
                busy        <= 1'b0;
`endif
            end
        end
    end

endmodule
